// File: rtl/spi_rb_bridge.sv
// rtl/spi_rb_bridge.sv - SPI mode-0 target acting as register-bank initiator
//
// Deserialises command/address/data bytes from an SPI host (MSB first) and
// drives the register bank; bank read data is serialised back on spi_miso.
// All pins are oversampled on clk (f_clk >= 8 x f_sclk).
//
// Frame: byte0 = command (0x80 write, 0x00 read), byte1 = address,
// byte2.. = data. Any other command sets the sticky frame_err.
//
// Build option: define SPI_RB_AUTOINC_EN for burst address auto-increment.
// Without it the address is fixed and bytes after the first data byte are
// ignored (no write strobe, MISO drives 0).
//
// Ports:
//   clk, resetb       system clock, synchronous active-low reset
//   spi_csn/sclk/mosi SPI inputs (asynchronous to clk)
//   spi_miso          target-to-host data (out register bit 7)
//   spi_miso_oe       pad enable, high only in DATA of a read frame
//   rb_address        register-bank address (ADR_BITS)
//   rb_data_write     write data
//   rb_data_read      registered bank read data (valid 1 clk after address)
//   rb_reg_en         access active
//   rb_write_en       single-clk write strobe
//   frame_err         sticky illegal-command flag, cleared only by reset

module spi_rb_bridge #(
  parameter int ADR_BITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                spi_csn,
  input  logic                spi_sclk,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic                spi_miso_oe,
  output logic [ADR_BITS-1:0] rb_address,
  output logic [7:0]          rb_data_write,
  input  logic [7:0]          rb_data_read,
  output logic                rb_reg_en,
  output logic                rb_write_en,
  output logic                frame_err
);

`ifdef SPI_RB_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic [2:0]             bit_cnt;
  logic [7:0]             sr_in;
  logic [7:0]             out_reg;
  logic [1:0]             cap_cnt;    // clocks until rb_data_read is captured
  logic                   inc_pend;   // address bump one clk after a data byte
  logic                   is_write;
  logic                   first_done; // first data byte of the frame completed

  logic       csn_s, sclk_s, mosi_s;
  logic       sclk_rise, sclk_fall, last_bit, data_ok;
  logic [7:0] rx_byte;

  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign rx_byte   = {sr_in[6:0], mosi_s};
  assign last_bit  = sclk_rise && (bit_cnt == 3'd7);
  // Without auto-increment only the first data byte of a frame is serviced.
  assign data_ok   = AUTOINC || !first_done;
  assign spi_miso  = out_reg[7];

  always_ff @(posedge clk) begin
    if (!resetb) begin
      csn_sync  <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state         <= IDLE;
      sclk_d        <= 1'b0;
      bit_cnt       <= 3'd0;
      sr_in         <= 8'h00;
      out_reg       <= 8'h00;
      cap_cnt       <= 2'd0;
      inc_pend      <= 1'b0;
      is_write      <= 1'b0;
      first_done    <= 1'b0;
      rb_address    <= '0;
      rb_data_write <= 8'h00;
      rb_reg_en     <= 1'b0;
      rb_write_en   <= 1'b0;
      spi_miso_oe   <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      sclk_d      <= sclk_s;
      rb_write_en <= 1'b0;

      // The address moves one clk after the byte so it stays put during the
      // write strobe; the read capture then follows 2 clk after the move.
      if (inc_pend) begin
        inc_pend   <= 1'b0;
        rb_address <= rb_address + {{(ADR_BITS-1){1'b0}}, 1'b1};
        cap_cnt    <= 2'd2;
      end else if (cap_cnt != 2'd0) begin
        cap_cnt <= cap_cnt - 2'd1;
        if (cap_cnt == 2'd1) out_reg <= rb_data_read;
      end

      if (csn_s) begin
        state       <= IDLE;
        bit_cnt     <= 3'd0;
        rb_reg_en   <= 1'b0;
        spi_miso_oe <= 1'b0;
        out_reg     <= 8'h00;
        cap_cnt     <= 2'd0;
        inc_pend    <= 1'b0;
        // A write whose 8th bit lands together with csn rising still completes.
        if (state == DATA && is_write && last_bit && data_ok) begin
          rb_data_write <= rx_byte;
          rb_write_en   <= 1'b1;
        end
      end else begin
        if (sclk_rise) begin
          sr_in   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
        end
        // bit_cnt == 0 marks the first fall of a byte, which must not shift.
        if (sclk_fall && state == DATA && bit_cnt != 3'd0)
          out_reg <= {out_reg[6:0], 1'b0};

        case (state)
          IDLE: state <= CMD;
          CMD: begin
            if (last_bit) begin
              if (rx_byte == 8'h80) begin
                is_write <= 1'b1;
                state    <= ADDR;
              end else if (rx_byte == 8'h00) begin
                is_write <= 1'b0;
                state    <= ADDR;
              end else begin
                frame_err <= 1'b1;
                state     <= IGNORE;
              end
            end
          end
          ADDR: begin
            if (last_bit) begin
              rb_address  <= rx_byte[ADR_BITS-1:0];
              rb_reg_en   <= 1'b1;
              cap_cnt     <= 2'd2;
              first_done  <= 1'b0;
              spi_miso_oe <= ~is_write;
              state       <= DATA;
            end
          end
          DATA: begin
            if (last_bit) begin
              first_done <= 1'b1;
              if (data_ok) begin
                inc_pend <= AUTOINC;
                if (is_write) begin
                  rb_data_write <= rx_byte;
                  rb_write_en   <= 1'b1;
                end
              end
              if (!AUTOINC) out_reg <= 8'h00;
            end
          end
          IGNORE: state <= IGNORE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_rb_bridge.sv
// tb/tb_spi_rb_bridge.sv - directed self-checking bench for spi_rb_bridge
module tb_spi_rb_bridge;

  localparam int HALF = 80;  // sclk half period in ns (clk period 10 ns)

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       spi_csn = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rb_address, rb_data_write, rb_data_read;
  logic       rb_reg_en, rb_write_en, frame_err;

  spi_rb_bridge #(.ADR_BITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetb(resetb),
    .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .rb_address(rb_address), .rb_data_write(rb_data_write),
    .rb_data_read(rb_data_read), .rb_reg_en(rb_reg_en),
    .rb_write_en(rb_write_en), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register-bank model: registered readback, 0x40 (dsp_cfg) resets to 0x1F.
  logic       bank_init = 1'b1;
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h40] <= 8'h1F;
    end else if (rb_write_en) begin
      mem[rb_address] <= rb_data_write;
    end
    rb_data_read <= mem[rb_address];
  end

  // Write strobe log and activity counters.
  int         wr_cnt = 0;
  int         long_cnt = 0;
  int         en_cycles = 0;
  logic       we_prev = 1'b0;
  logic [7:0] wr_adr [0:63];
  logic [7:0] wr_dat [0:63];
  always @(posedge clk) begin
    we_prev <= rb_write_en;
    if (rb_write_en) begin
      wr_adr[wr_cnt[5:0]] <= rb_address;
      wr_dat[wr_cnt[5:0]] <= rb_data_write;
      wr_cnt <= wr_cnt + 1;
    end
    if (rb_write_en && we_prev) long_cnt <= long_cnt + 1;
    if (rb_reg_en) en_cycles <= en_cycles + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] rxb [0:3];
  logic       oe_b [0:3];

  task automatic spi_bits(input int k, input logic [7:0] tx, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      #(HALF);
      rxb[k][i] = spi_miso;
      oe_b[k]   = oe_b[k] | spi_miso_oe;
      spi_sclk  = 1'b1;
      #(HALF);
      spi_sclk  = 1'b0;
    end
  endtask

  task automatic frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] tx [0:3];
    tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3;
    for (int k = 0; k < 4; k++) begin
      rxb[k] = 8'h00;
      oe_b[k] = 1'b0;
    end
    spi_csn = 1'b0;
    #(HALF);
    for (int k = 0; k < n; k++) spi_bits(k, tx[k], 8);
    #(HALF);
    spi_csn = 1'b1;
    #(HALF * 3);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_adr"},  {24'h0, rb_address}, 32'h0);
    chk({tag, "_wd"},   {24'h0, rb_data_write}, 32'h0);
    chk({tag, "_en"},   {31'h0, rb_reg_en}, 32'h0);
    chk({tag, "_we"},   {31'h0, rb_write_en}, 32'h0);
    chk({tag, "_miso"}, {31'h0, spi_miso}, 32'h0);
    chk({tag, "_oe"},   {31'h0, spi_miso_oe}, 32'h0);
    chk({tag, "_err"},  {31'h0, frame_err}, 32'h0);
  endtask

  int w0, e0;

  initial begin
    repeat (4) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    resetb = 1'b1;
    bank_init = 1'b0;
    repeat (10) @(negedge clk);

    // Read dsp_cfg reset value; OE only during the data byte.
    w0 = wr_cnt;
    frame(3, 8'h00, 8'h40, 8'h00, 8'h00);
    chk("rd40_data", {24'h0, rxb[2]}, 32'h1F);
    chk("rd40_oe_b0", {31'h0, oe_b[0]}, 32'h0);
    chk("rd40_oe_b1", {31'h0, oe_b[1]}, 32'h0);
    chk("rd40_oe_b2", {31'h0, oe_b[2]}, 32'h1);
    chk("rd40_oe_end", {31'h0, spi_miso_oe}, 32'h0);
    chk("rd40_en_end", {31'h0, rb_reg_en}, 32'h0);
    chk("rd40_nowr", wr_cnt - w0, 32'd0);

    // Single write then readback.
    w0 = wr_cnt;
    frame(3, 8'h80, 8'h01, 8'hA5, 8'h00);
    chk("wr01_cnt", wr_cnt - w0, 32'd1);
    chk("wr01_adr", {24'h0, wr_adr[w0[5:0]]}, 32'h01);
    chk("wr01_dat", {24'h0, wr_dat[w0[5:0]]}, 32'hA5);
    chk("wr01_pulse", long_cnt, 32'd0);
    frame(3, 8'h00, 8'h01, 8'h00, 8'h00);
    chk("rd01_data", {24'h0, rxb[2]}, 32'hA5);

    // Burst write across the address wrap.
    w0 = wr_cnt;
    frame(4, 8'h80, 8'hFF, 8'h11, 8'h22);
`ifdef SPI_RB_AUTOINC_EN
    chk("burst_cnt", wr_cnt - w0, 32'd2);
    chk("burst_adr1", {24'h0, wr_adr[w0[5:0] + 6'd1]}, 32'h00);
    chk("burst_dat1", {24'h0, wr_dat[w0[5:0] + 6'd1]}, 32'h22);
`else
    chk("burst_cnt", wr_cnt - w0, 32'd1);
`endif
    chk("burst_adr0", {24'h0, wr_adr[w0[5:0]]}, 32'hFF);
    chk("burst_dat0", {24'h0, wr_dat[w0[5:0]]}, 32'h11);
    chk("burst_pulse", long_cnt, 32'd0);

    // Burst read across the wrap.
    frame(4, 8'h00, 8'hFF, 8'h00, 8'h00);
    chk("brd_b2", {24'h0, rxb[2]}, 32'h11);
`ifdef SPI_RB_AUTOINC_EN
    chk("brd_b3", {24'h0, rxb[3]}, 32'h22);
`else
    chk("brd_b3", {24'h0, rxb[3]}, 32'h00);
`endif

    // Illegal command.
    w0 = wr_cnt;
    e0 = en_cycles;
    frame(3, 8'h42, 8'h01, 8'h77, 8'h00);
    chk("bad_err", {31'h0, frame_err}, 32'h1);
    chk("bad_nowr", wr_cnt - w0, 32'd0);
    chk("bad_noen", en_cycles - e0, 32'd0);

    // Abort after 5 data bits, then a normal write.
    w0 = wr_cnt;
    spi_csn = 1'b0;
    #(HALF);
    spi_bits(0, 8'h80, 8);
    spi_bits(1, 8'h03, 8);
    spi_bits(2, 8'hFF, 5);
    #(HALF);
    spi_csn = 1'b1;
    #(HALF * 3);
    chk("abort_nowr", wr_cnt - w0, 32'd0);
    frame(3, 8'h80, 8'h03, 8'h5A, 8'h00);
    chk("after_abort_cnt", wr_cnt - w0, 32'd1);
    chk("after_abort_adr", {24'h0, wr_adr[w0[5:0]]}, 32'h03);
    chk("after_abort_dat", {24'h0, wr_dat[w0[5:0]]}, 32'h5A);
    chk("err_sticky", {31'h0, frame_err}, 32'h1);

    // Reset during the address byte.
    spi_csn = 1'b0;
    #(HALF);
    spi_bits(0, 8'h80, 8);
    spi_bits(1, 8'hC3, 4);
    @(negedge clk);
    resetb = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("midrst");
    spi_sclk = 1'b0;
    spi_csn = 1'b1;
    repeat (10) @(negedge clk);
    resetb = 1'b1;
    repeat (10) @(negedge clk);

    // Bridge is back in IDLE and frames work again.
    frame(3, 8'h00, 8'h03, 8'h00, 8'h00);
    chk("post_rst_rd", {24'h0, rxb[2]}, 32'h5A);
    chk("post_rst_err", {31'h0, frame_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_rb_bridge.md
Name: spi_rb_bridge

Overview:
- SPI target (mode 0, MSB first) that acts as the bus initiator for the toi2s register bank.
- Deserialises command, address and data bytes from an external host. Drives address, data_write, reg_en and write_en toward the register bank, and serialises bank read data back on MISO.
- Sits between the chip pads and the register bank. All logic runs on clk; the SPI pins are oversampled.

Parameters:
- ADR_BITS, 8, register-bank address width; the address byte is truncated to ADR_BITS.
- SYNC_STAGES, 2, synchroniser depth on spi_csn, spi_sclk and spi_mosi (legal range 2..3).

Ports:
- clk  in  1  system clock; must satisfy f_clk >= 8 x f_sclk.
- resetb  in  1  reset; clock clk, reset resetb, synchronous, active-low.
- spi_csn  in  1  chip select, active low, asynchronous to clk.
- spi_sclk  in  1  SPI clock, idle low.
- spi_mosi  in  1  host-to-target data.
- spi_miso  out  1  target-to-host data.
- spi_miso_oe  out  1  pad output enable; high only while csn is low and the state is DATA of a read.
- rb_address  out  ADR_BITS  register-bank address.
- rb_data_write  out  8  write data.
- rb_data_read  in  8  registered bank read data; valid 1 clk after rb_address changes.
- rb_reg_en  out  1  access active.
- rb_write_en  out  1  single-clk write strobe.
- frame_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values: rb_address=0, rb_data_write=0, rb_reg_en=0, rb_write_en=0, spi_miso=0, spi_miso_oe=0, frame_err=0, state=IDLE.
- Synchronisers, then edge detection on synced sclk. A rise samples mosi into the 8-bit shift-in register. A fall shifts the out register.
- The bit counter (3 bits) and the state machine reset to the start of a frame whenever synced csn is high.
- Frame format: byte0 = command, byte1 = address, byte2.. = data.
- Command byte 0x80 = write, 0x00 = read. Any other value sets frame_err and enters IGNORE until csn rises.
- States:
  - IDLE: csn falls -> CMD.
  - CMD: 8th rise -> ADDR, or IGNORE on an illegal command.
  - ADDR: 8th rise -> latch rb_address, assert rb_reg_en, -> DATA.
  - DATA: stays in DATA until csn rises.
  - IGNORE: csn rises -> IDLE.
  - Any state: csn rises -> IDLE.
- Write: on the 8th rise of a data byte, load rb_data_write with that byte and pulse rb_write_en for exactly 1 clk on the following cycle. rb_address is stable during the pulse.
- Read:
  - 2 clk after rb_address is latched, capture rb_data_read into the out register. spi_miso is the out register bit7.
  - The first sclk fall after the address byte does not shift. Falls 2..8 within a byte shift left.
  - On the 8th rise, the next byte's data is fetched with the same 2-clk capture rule.
- Burst addressing: after each completed data byte, rb_address becomes address+1, wrapping from 2^ADR_BITS-1 to 0.
- rb_reg_en drops and spi_miso_oe drops 1 clk after synced csn rises.
- Aborts (csn high before the 8th bit, or resetb low at any time): discard the partial byte and issue no write strobe. A write strobe is never issued for a partial data byte.
- If csn rises in the same clk as the 8th rise of a write, the write completes.

Optional Feature:
- SPI_RB_AUTOINC_EN.
- Defined: burst auto-increment as described above.
- Undefined: rb_address is fixed for the whole frame. Bytes after the first data byte are ignored: no write strobe, and MISO drives 0.

Test Plan:
- Write 0x80,0x01,0xA5 -> one rb_write_en pulse with rb_address=0x01 and rb_data_write=0xA5; the bank pwm_duty readback is 0xA5.
- Read 0x00,0x40,dummy after reset -> MISO returns 0x1F (dsp_cfg reset value); spi_miso_oe is high only during byte2.
- Burst write 0x80,0xFF,0x11,0x22 with SPI_RB_AUTOINC_EN -> writes 0x11@0xFF then 0x22@0x00 (wrap). Without the macro -> only 0x11@0xFF.
- Command 0x42 -> frame_err=1, no rb_write_en, rb_reg_en stays 0. frame_err holds after csn rises until resetb.
- csn rises after 5 bits of the write data byte -> no rb_write_en; the next full frame writes normally.
- resetb low mid-frame (during the address byte) -> all outputs return to reset values on the next clk; state=IDLE.
